fenpei_buf: RTL and testbench
=============================

Name: fenpei_buf

Overview:
- Buffered 1-to-2 distributor for the datapath: the inverse of the 2:1 word selector.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and routes it to output port 1 (sel=0) or output port 2 (sel=1).
- Each output has its own 2-entry FIFO, so a stalled sink does not block traffic to the other sink once its own FIFO has room.
- Sits between a shared producer (e.g. memory read return) and two consumers (e.g. instruction path and data path). Per-port delivered-word counters support debug.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of each delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  word to distribute.
- in_valid  input  1  in_data valid.
- sel  input  1  destination: 0 -> port 1, 1 -> port 2; sampled with in_data.
- in_ready  output  1  selected port's FIFO can accept this cycle.
- out1_data  output  WIDTH  head word of port 1 FIFO.
- out1_valid  output  1  port 1 FIFO non-empty.
- out1_ready  input  1  port 1 sink accepts.
- out2_data  output  WIDTH  head word of port 2 FIFO.
- out2_valid  output  1  port 2 FIFO non-empty.
- out2_ready  input  1  port 2 sink accepts.
- cnt1  output  CNT_W  words delivered on port 1.
- cnt2  output  CNT_W  words delivered on port 2.

Behaviour:
- Reset: all actions at the clk edge while rst=1.
  - Both FIFO occupancies go to 0 and read/write pointers to 0.
  - out1_valid=0, out2_valid=0, cnt1=0, cnt2=0.
  - out*_data=0 (storage cleared).
  - rst overrides any push or pop in that cycle. Words in flight mid-operation are discarded, not delivered.
- in_ready is combinational:
  - sel=0: in_ready = (occ1 < 2).
  - sel=1: in_ready = (occ2 < 2).
  - in_ready does not depend on in_valid.
  - No pass-through when full: a pop in the same cycle does not raise in_ready while occ=2.
- Push: occurs when in_valid & in_ready at the rising edge. The word is written into the FIFO selected by sel.
  - The word is visible at that port's out_data with out_valid=1 no earlier than the next cycle (latency 1 cycle when the FIFO was empty).
- Pop: port k pops when outk_valid & outk_ready. The head advances and occk decrements.
- Simultaneous push and pop on the same port (occ=1): occ stays 1, the new word becomes the head next cycle, and order is preserved.
  - At occ=0 a push and a pop cannot coincide, because valid=0.
- Ordering:
  - Strict FIFO order per port.
  - No ordering guarantee between ports.
  - sel may change every cycle.
- Output timing: outk_data and outk_valid come straight from registers/storage (no combinational path from in_*). outk_data is stable while outk_valid=1 and outk_ready=0.
- Occupancy: 2-bit counter per port, legal values 0..2. Pointers are 1 bit and wrap 1->0.
- Counters: cntk increments by 1 on each port-k pop. It wraps modulo 2^CNT_W (all-ones -> 0) with no saturation flag.
- Throughput: 1 word/cycle sustained to a single port when its sink holds ready=1 continuously.
- Corner cases:
  - in_valid=1 while the target FIFO is full: no state change. The producer holds the word.
  - outk_ready=1 while outk_valid=0: ignored.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> in_ready=1, both out_valid=0, cnt1=cnt2=0, no word stored.
- Basic routing: push 0x11111111 (sel=0), then 0x22222222 (sel=1), sinks ready -> out1 shows 0x11111111 one cycle after its push and out2 shows 0x22222222 one cycle after its push; cnt1=1, cnt2=1.
- Backpressure/full: out1_ready=0, push A,B,C with sel=0 -> A and B accepted, in_ready=0 for C. Raise out1_ready -> A, B, C delivered in order; cnt1=3.
- Independence: port 1 full and stalled, sel=1 stream 0x5..0x8 -> all accepted and delivered on port 2 in order; port 1 contents unchanged.
- Simultaneous push/pop at occ=1, with in_valid held and out1_ready=1 for 8 cycles -> 1 word/cycle, occ1 stays 1, values in order, cnt1 advances by 1 per cycle.
- Counter wrap and mid-reset: CNT_W=4, deliver 17 words on port 2 -> cnt2=1. Then fill both FIFOs and pulse rst -> both out_valid=0 and counters 0 next cycle, no stale word appears afterward.

Source files
------------

// File: rtl/fenpei_buf.sv
// Buffered 1-to-2 word distributor: each output port has its own 2-entry FIFO
// and a wrapping count of words delivered on that port.
module fenpei_buf #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             sel,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2
);

   logic [WIDTH-1:0] mem1 [2];
   logic [WIDTH-1:0] mem2 [2];
   logic             wp1, rp1, wp2, rp2;
   logic [1:0]       occ1, occ2;
   logic             push1, push2, pop1, pop2;

   // Readiness reflects only the selected FIFO's current occupancy; no pass-through when full.
   always_comb begin
      in_ready = sel ? (occ2 < 2'd2) : (occ1 < 2'd2);
      push1    = in_valid & in_ready & ~sel;
      push2    = in_valid & in_ready & sel;
      pop1     = out1_valid & out1_ready;
      pop2     = out2_valid & out2_ready;
   end

   always_comb begin
      out1_valid = (occ1 != 2'd0);
      out2_valid = (occ2 != 2'd0);
      out1_data  = mem1[rp1];
      out2_data  = mem2[rp2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp1  <= 1'b0;
         rp1  <= 1'b0;
         occ1 <= 2'd0;
         cnt1 <= '0;
         for (int i = 0; i < 2; i++) mem1[i] <= '0;
      end else begin
         if (push1) begin
            mem1[wp1] <= in_data;
            wp1       <= ~wp1;
         end
         if (pop1) begin
            rp1  <= ~rp1;
            cnt1 <= cnt1 + 1'b1;
         end
         if (push1 && !pop1) begin
            occ1 <= occ1 + 2'd1;
         end else if (!push1 && pop1) begin
            occ1 <= occ1 - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp2  <= 1'b0;
         rp2  <= 1'b0;
         occ2 <= 2'd0;
         cnt2 <= '0;
         for (int i = 0; i < 2; i++) mem2[i] <= '0;
      end else begin
         if (push2) begin
            mem2[wp2] <= in_data;
            wp2       <= ~wp2;
         end
         if (pop2) begin
            rp2  <= ~rp2;
            cnt2 <= cnt2 + 1'b1;
         end
         if (push2 && !pop2) begin
            occ2 <= occ2 + 2'd1;
         end else if (!push2 && pop2) begin
            occ2 <= occ2 - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_fenpei_buf.sv
// Bench for fenpei_buf: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_fenpei_buf;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             sel;
   logic             in_ready;
   logic [WIDTH-1:0] out1_data, out2_data;
   logic             out1_valid, out2_valid;
   logic             out1_ready, out2_ready;
   logic [CNT_W-1:0] cnt1, cnt2;

   int total = 0;
   int bad   = 0;

   fenpei_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .sel        (sel),
      .in_ready   (in_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready),
      .cnt1       (cnt1),
      .cnt2       (cnt2)
   );

   always #5 clk = ~clk;

   // Reference model: one queue of pending words per port, plus delivered counts.
   logic [WIDTH-1:0] q1 [$];
   logic [WIDTH-1:0] q2 [$];
   logic [CNT_W-1:0] m_cnt1, m_cnt2;
   bit               armed = 0;

   always @(posedge clk) begin
      bit p1, p2;
      if (rst) begin
         q1.delete();
         q2.delete();
         m_cnt1 = '0;
         m_cnt2 = '0;
         armed  = 1;
      end else if (armed) begin
         p1 = in_valid && !sel && (q1.size() < 2);
         p2 = in_valid && sel && (q2.size() < 2);
         if (out1_ready && q1.size() > 0) begin
            void'(q1.pop_front());
            m_cnt1 = m_cnt1 + 1'b1;
         end
         if (out2_ready && q2.size() > 0) begin
            void'(q2.pop_front());
            m_cnt2 = m_cnt2 + 1'b1;
         end
         if (p1) q1.push_back(in_data);
         if (p2) q2.push_back(in_data);
      end
   end

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Compare process: outputs checked against the model halfway through every cycle.
   always @(negedge clk) begin
      if (armed) begin
         chk("m_out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
         chk("m_out2_valid", {31'd0, out2_valid}, {31'd0, q2.size() != 0});
         if (q1.size() != 0) chk("m_out1_data", out1_data, q1[0]);
         if (q2.size() != 0) chk("m_out2_data", out2_data, q2[0]);
         chk("m_cnt1", {28'd0, cnt1}, {28'd0, m_cnt1});
         chk("m_cnt2", {28'd0, cnt2}, {28'd0, m_cnt2});
         chk("m_in_ready", {31'd0, in_ready},
             {31'd0, sel ? (q2.size() < 2) : (q1.size() < 2)});
      end
   end

   task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r1, input logic r2, input logic rs);
      in_valid   = v;
      sel        = s;
      in_data    = d;
      out1_ready = r1;
      out2_ready = r2;
      rst        = rs;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);

      // Reset held two cycles with in_valid=1
      tick();
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("rst_out2_valid", {31'd0, out2_valid}, 32'd0);
      chk("rst_cnt1", {28'd0, cnt1}, 32'd0);
      chk("rst_cnt2", {28'd0, cnt2}, 32'd0);
      chk("rst_out1_data", out1_data, 32'd0);

      // Basic routing
      drive(1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
      tick();
      chk("basic_out1_valid", {31'd0, out1_valid}, 32'd1);
      chk("basic_out1_data", out1_data, 32'h1111_1111);
      drive(1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
      tick();
      chk("basic_out2_data", out2_data, 32'h2222_2222);
      chk("basic_cnt1", {28'd0, cnt1}, 32'd1);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("basic_cnt2", {28'd0, cnt2}, 32'd1);

      // Backpressure: third word refused until a slot frees, order kept
      do_reset();
      drive(1'b1, 1'b0, 32'hA, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'hB, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'hC, 1'b0, 1'b0, 1'b0);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);
      chk("full_no_passthru", {31'd0, in_ready}, 32'd0);
      chk("full_head_a", out1_data, 32'hA);
      tick();
      chk("full_head_b", out1_data, 32'hB);
      chk("full_ready_again", {31'd0, in_ready}, 32'd1);
      tick();
      chk("full_head_c", out1_data, 32'hC);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("full_drained", {31'd0, out1_valid}, 32'd0);
      chk("full_cnt1", {28'd0, cnt1}, 32'd3);

      // Independence: port 1 full and stalled while port 2 streams
      do_reset();
      drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b0);
      tick();
      for (int i = 5; i <= 8; i++) begin
         drive(1'b1, 1'b1, i, 1'b0, 1'b1, 1'b0);
         chk("indep_in_ready", {31'd0, in_ready}, 32'd1);
         tick();
         chk("indep_out2_data", out2_data, i);
         chk("indep_out1_held", out1_data, 32'hA1);
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("indep_cnt2", {28'd0, cnt2}, 32'd4);
      chk("indep_cnt1", {28'd0, cnt1}, 32'd0);

      // Simultaneous push/pop at occupancy 1: one word per cycle
      do_reset();
      drive(1'b1, 1'b0, 32'd100, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 101 + i, 1'b1, 1'b0, 1'b0);
         chk("tput_in_ready", {31'd0, in_ready}, 32'd1);
         tick();
         chk("tput_out1_data", out1_data, 101 + i);
      end
      chk("tput_cnt1", {28'd0, cnt1}, 32'd8);

      // Counter wrap: 17 deliveries on a 4-bit counter leave 1
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b1, 32'h200 + i, 1'b0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("wrap_cnt2", {28'd0, cnt2}, 32'd1);

      // Mid-operation reset discards buffered words
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i[0], 32'h300 + i, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h3FF, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      chk("mrst_out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("mrst_out2_valid", {31'd0, out2_valid}, 32'd0);
      chk("mrst_cnt2", {28'd0, cnt2}, 32'd0);
      tick();
      tick();
      chk("mrst_no_stale1", {31'd0, out1_valid}, 32'd0);
      chk("mrst_no_stale2", {31'd0, out2_valid}, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom % 4) != 0, $urandom % 2, $urandom, ($urandom % 3) != 0,
               ($urandom % 3) == 0, ($urandom % 150) == 0);
         tick();
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
